// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the hex font for the Basys3 seven-segment display.
// The display is common-anode, so segments, decimal point and anodes are all active-low.
package sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // One complete display image: four nibbles, decimal points and digit enables.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_data_t;

  // Active-low font, bit order gfedcba (bit 0 = segment a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Valid/ready write port carrying a new display image into the scan controller.
interface sevenseg_scan_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_value;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_digit_en;

  modport master (output wr_valid, wr_value, wr_dp, wr_digit_en, input wr_ready);
  modport slave  (input wr_valid, wr_value, wr_dp, wr_digit_en, output wr_ready);
endinterface

// File: rtl/sevenseg_scan_ctrl_decode.sv
// Combinational nibble-to-segment decoder, shared with other display peripherals.
module hex7seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_nibble);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit time-multiplexed scan controller with per-slot blanking and
// tear-free updates: new data waits in a pending buffer until the end of a frame.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  sevenseg_scan_ctrl_if.slave  wr,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an,
  output logic                 frame_done
);

  localparam int SLOT_CYCLES = CLK_FREQ / (NUM_DIGITS * REFRESH_HZ);
  localparam int ON_CYCLES   = SLOT_CYCLES - BLANK_CYCLES;
  localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  if (ON_CYCLES < 1) begin : g_cfg_err
    $error("sevenseg_scan_ctrl: BLANK_CYCLES leaves no ON time in a digit slot");
  end

  scan_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  disp_data_t       r_active, r_pending_data, w_active_nxt;
  logic             r_pending;
  logic [6:0]       r_seg, w_seg_nxt, w_dec_seg;
  logic             r_dp, w_dp_nxt;
  logic [3:0]       r_an, w_an_nxt;
  logic             r_frame_done, w_fd_nxt;
  logic             w_accept, w_on_last, w_commit;
  logic [3:0]       w_nibble;

  assign wr.wr_ready = ~r_pending;
  assign w_accept    = wr.wr_valid & ~r_pending;
  assign w_on_last   = (r_state == ON) && (r_cnt == ON_LAST);
  assign w_commit    = w_on_last && (r_idx == 2'd3);

  // Data committed at this edge must already drive the first slot of the next frame.
  assign w_active_nxt = (w_commit && r_pending) ? r_pending_data : r_active;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking, so all registers update from
    // the same pre-edge values and the order of statements inside the block is irrelevant.
    if (rst) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: BLANK and ON alternate, the digit index advancing after each ON.
  always_comb begin
    // NOTE: defaults assigned up front so that no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    case (r_state)
      BLANK: begin
        if ((BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST)) begin
          w_state_nxt = ON;
          w_cnt_nxt   = '0;
        end
      end
      ON: begin
        if (w_on_last) begin
          w_state_nxt = (BLANK_CYCLES == 0) ? ON : BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
    endcase
  end

  assign w_nibble = w_active_nxt.value[{w_idx_nxt, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // Output logic, evaluated on the upcoming state so registered pins change on state entry.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    w_an_nxt  = AN_OFF;
    if ((w_state_nxt == ON) && w_active_nxt.en[w_idx_nxt]) begin
      w_seg_nxt            = w_dec_seg;
      w_dp_nxt             = ~w_active_nxt.dp[w_idx_nxt];
      w_an_nxt[w_idx_nxt]  = 1'b0;
    end
    w_fd_nxt = (w_state_nxt == ON) && (w_idx_nxt == 2'd3) && (w_cnt_nxt == ON_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  // Write buffer: accept only when empty; a frame-end commit moves it to the active image.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending      <= 1'b0;
      r_pending_data <= '0;
      r_active       <= '0;
    end else begin
      r_active <= w_active_nxt;
      if (w_accept) begin
        r_pending      <= 1'b1;
        r_pending_data <= '{value: wr.wr_value, dp: wr.wr_dp, en: wr.wr_digit_en};
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: a frame-arithmetic model predicts every output cycle and a
// separate monitor compares the DUT pins against the queued predictions.
module tb_sevenseg_scan_ctrl;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl_if wr_if ();

  sevenseg_scan_ctrl #(
    .CLK_FREQ     (4000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ready;
    logic       fd;
    int         t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: cycle index since reset, pending buffer and displayed image.
  int          t = 0;
  bit          started = 0;
  bit          m_pending = 0;
  logic [15:0] p_val = '0, a_val = '0;
  logic [3:0]  p_dp = '0, p_en = '0, a_dp = '0, a_en = '0;

  function automatic exp_t expect_now();
    exp_t e;
    int   pos, slot, sp;
    logic [15:0] v;
    pos  = t % FRAME;
    slot = pos / SLOT;
    sp   = pos % SLOT;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.an  = 4'hF;
    if (sp >= BLANK && a_en[slot]) begin
      v     = a_val >> (4 * slot);
      e.seg = font[v[3:0]];
      e.dp  = ~a_dp[slot];
      e.an  = ~(4'b0001 << slot);
    end
    e.ready = !m_pending;
    e.fd    = (pos == FRAME - 1);
    e.t     = t;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v,
                       input int tt);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, tt, act, exp_v);
    end
  endtask

  // One clock period: record the prediction for the current cycle, drive inputs,
  // then advance the model across the coming edge.
  task automatic cycle(input bit v, input logic [15:0] val, input logic [3:0] d,
                       input logic [3:0] e, input bit r);
    bit acc;
    @(negedge clk);
    if (started) q.push_back(expect_now());
    rst                  = r;
    wr_if.wr_valid       = v;
    wr_if.wr_value       = val;
    wr_if.wr_dp          = d;
    wr_if.wr_digit_en    = e;
    if (r) begin
      t = 0; m_pending = 0; started = 1;
      p_val = '0; p_dp = '0; p_en = '0;
      a_val = '0; a_dp = '0; a_en = '0;
    end else begin
      acc = v && !m_pending;
      if ((t % FRAME == FRAME - 1) && m_pending) begin
        a_val = p_val; a_dp = p_dp; a_en = p_en;
        m_pending = 0;
      end
      if (acc) begin
        p_val = val; p_dp = d; p_en = e;
        m_pending = 1;
      end
      t++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic write(input logic [15:0] val, input logic [3:0] d, input logic [3:0] e);
    cycle(1'b1, val, d, e, 1'b0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) idle(1);
  endtask

  // Monitor: the DUT presents a new output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("seg",        16'(seg),            16'(e.seg),   e.t);
        check("dp",         16'(dp),             16'(e.dp),    e.t);
        check("an",         16'(an),             16'(e.an),    e.t);
        check("wr_ready",   16'(wr_if.wr_ready), 16'(e.ready), e.t);
        check("frame_done", 16'(frame_done),     16'(e.fd),    e.t);
      end
    end
  end

  initial begin
    logic [3:0] nib;
    wr_if.wr_valid    = 1'b0;
    wr_if.wr_value    = '0;
    wr_if.wr_dp       = '0;
    wr_if.wr_digit_en = '0;

    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1);
    idle(45);

    write(16'h12AF, 4'b0100, 4'hF);
    idle(3);
    write(16'hFFFF, 4'hF, 4'hF);
    idle(90);

    write(16'h8888, 4'h0, 4'b0101);
    idle(90);

    wait_phase(FRAME - 1);
    write(16'hC0DE, 4'b1001, 4'hF);
    idle(90);

    wait_phase(10);
    write(16'h789A, 4'b0010, 4'hF);
    wait_phase(24);
    repeat (2) cycle(1'b0, '0, '0, '0, 1'b1);
    idle(50);

    for (int n = 0; n < 16; n++) begin
      nib = 4'(n);
      write({12'h000, nib}, {3'b000, nib[0]}, 4'b0001);
      idle(80);
    end

    repeat (1500)
      cycle($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);

    idle(2);
    @(negedge clk);
    #2;
    check("queue_drained", 16'(q.size()), 16'd0, t);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
